xor3_parity_sched: RTL
======================

Name: xor3_parity_sched

Overview:
Shares one 3-input XOR cell among NREQ requesters to compute the parity of WIDTH-bit words.
- Round-robin arbiter grants one requester; a sequencer then feeds the XOR cell two data bits plus the running accumulator per cycle.
- Result is returned with the requester ID over a valid/ready handshake.
- Sits between client blocks needing parity/check bits and the single shared XOR datapath.

Parameters:
WIDTH, 8, data word width; must be even and >= 2
NREQ, 2, number of requesters; 2..8
IDW, 3, width of res_id; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request strobe
req_data  input  NREQ*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot accept, combinational from state and grant
odd_mode  input  1  0 = even parity, 1 = odd parity; sampled at accept
res_valid  output  1  result available
res_parity  output  1  parity result
res_id  output  IDW  index of the requester that owns the result
res_ready  input  1  consumer accepts result

Behaviour:
- Interface: one clock clk; rst_n asynchronous, active-low.
- Reset values: req_ready=0, res_valid=0, res_parity=0, res_id=0, state=IDLE, shift reg=0, count=0, last_grant=NREQ-1 (so requester 0 has first priority).
- States:
  - IDLE: compute grant g = first i with req_valid[i]=1, searching from last_grant+1 with wrap-around. Assert req_ready[g] only. On the edge where req_valid[g]=1:
    - capture req_data slice g into shift reg
    - acc <= odd_mode, res_id <= g, count <= 0
    - go to RUN
  - If no req_valid: remain in IDLE with req_ready=0.
  - RUN: each cycle acc <= xor3(acc, sh[0], sh[1]); sh <= sh>>2; count++. When count == WIDTH/2-1, the update still occurs and the next state is DONE.
  - DONE: res_valid=1, res_parity=acc. Outputs are held stable until res_ready=1. On handshake: last_grant <= res_id, go to IDLE.
- Latency: res_valid rises WIDTH/2 edges after the accept edge (4 cycles for WIDTH=8).
- Throughput: at most one job per WIDTH/2+2 cycles. IDLE always costs one cycle after a result handshake.
- Parity rule: res_parity = (XOR-reduce of all WIDTH bits) XOR odd_mode.
- req_ready is 0 in RUN and DONE. A req_valid seen there stays pending, with no effect and no loss of fairness.
- Requester deasserting req_valid before grant is legal and is simply skipped.
- Changes to req_data or odd_mode after the accept edge do not affect the job in flight.
- res_ready while res_valid=0 is ignored.
- Simultaneous requests: round-robin order. A requester just served is lowest priority on the next arbitration.
- rst_n low at any time (including mid-RUN or DONE): job is discarded immediately and all registers take reset values; no partial result is emitted.

Optional Feature:
Macro XOR3_PARITY_STAT_EN.
- Defined: adds output port stat_jobs (16 bits), reset 0. It increments on each result handshake and saturates at 16'hFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package xor3_sched_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - parity-mode constants PAR_EVEN=0, PAR_ODD=1
  - stat counter width constant STAT_W=16
- One sub-module, xor3_cell: purely combinational 3-input XOR (y = x1^x2^x3). It is instantiated once as the shared datapath; all sequencing lives in the parent.

Test Plan:
- WIDTH=8, NREQ=2, req0 data 8'hB5, odd_mode=0 → req_ready[0] asserts in IDLE; 4 cycles after accept res_valid=1, res_parity=1, res_id=0.
- Same data with odd_mode=1 → res_parity=0. Data 8'h00 with odd_mode=0 → res_parity=0.
- Both req_valid held high continuously, res_ready=1 → grants alternate 0,1,0,1; res_id sequence 0,1,0,1; each job is 6 cycles accept-to-accept.
- res_ready held 0 for 10 cycles in DONE → res_valid, res_parity and res_id stay stable; req_ready stays 0; the result is accepted once res_ready=1.
- rst_n pulsed low during the 2nd RUN cycle → outputs are 0 immediately; after release a new req1 with 8'h01 is granted and gives res_parity=1, res_id=1.
- With XOR3_PARITY_STAT_EN defined: 3 completed jobs → stat_jobs=3. Preloading 16'hFFFE, then 3 jobs → stat_jobs=16'hFFFF.

Source files
------------

// File: rtl/xor3_sched_pkg.sv
// Shared types and constants for the time-shared XOR3 parity scheduler.
package xor3_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/xor3_cell.sv
// Single shared 3-input XOR datapath cell.
module xor3_cell (
   input  logic x1,
   input  logic x2,
   input  logic x3,
   output logic y
);

   assign y = x1 ^ x2 ^ x3;

endmodule

// File: rtl/xor3_parity_sched.sv
// Round-robin scheduler feeding NREQ parity jobs through one XOR3 cell, two bits per cycle.
// Optional job counter port stat_jobs when XOR3_PARITY_STAT_EN is defined.
module xor3_parity_sched
   import xor3_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDW   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  odd_mode,
   output logic                  res_valid,
   output logic                  res_parity,
   output logic [IDW-1:0]        res_id,
   input  logic                  res_ready
`ifdef XOR3_PARITY_STAT_EN
   ,
   output logic [STAT_W-1:0]     stat_jobs
`endif
);

   localparam int unsigned HALF  = WIDTH / 2;
   localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q;
   logic             acc_q;
   logic [CNT_W-1:0] count_q;
   logic [IDW-1:0]   last_grant_q;
   logic [IDW-1:0]   res_id_q;
   logic             res_valid_q;
   logic             res_parity_q;

   logic [IDW-1:0]   grant_c;
   logic             any_req_c;
   logic             accept_c;
   logic             done_hs_c;
   logic             xor_y_c;
   logic [WIDTH-1:0] grant_data_c;

   // Round-robin search starting one past the last served requester
   always_comb begin
      grant_c   = '0;
      any_req_c = 1'b0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!any_req_c && req_valid[i] &&
                (((int'(last_grant_q) + k) % int'(NREQ)) == i)) begin
               any_req_c = 1'b1;
               grant_c   = IDW'(i);
            end
         end
      end
   end

   always_comb begin
      grant_data_c = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_c == IDW'(i)) grant_data_c = req_data[i*WIDTH +: WIDTH];
      end
   end

   assign accept_c  = (state_q == IDLE) && any_req_c;
   assign done_hs_c = (state_q == DONE) && res_ready;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         req_ready[i] = accept_c && (grant_c == IDW'(i));
      end
   end

   xor3_cell u_cell (
      .x1 (acc_q),
      .x2 (sh_q[0]),
      .x3 (sh_q[1]),
      .y  (xor_y_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = RUN;
         RUN:     if (count_q == LAST_CNT) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Job datapath; a job is latched at accept so later input changes cannot leak in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q         <= '0;
         acc_q        <= PAR_EVEN;
         count_q      <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         res_id_q     <= '0;
         res_valid_q  <= 1'b0;
         res_parity_q <= 1'b0;
      end else if (accept_c) begin
         sh_q     <= grant_data_c;
         acc_q    <= odd_mode;
         res_id_q <= grant_c;
         count_q  <= '0;
      end else if (state_q == RUN) begin
         acc_q   <= xor_y_c;
         sh_q    <= sh_q >> 2;
         count_q <= count_q + CNT_W'(1);
         if (count_q == LAST_CNT) begin
            res_valid_q  <= 1'b1;
            res_parity_q <= xor_y_c;
         end
      end else if (done_hs_c) begin
         res_valid_q  <= 1'b0;
         res_parity_q <= 1'b0;
         last_grant_q <= res_id_q;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_parity = res_parity_q;
   assign res_id     = res_id_q;

`ifdef XOR3_PARITY_STAT_EN
   logic [STAT_W-1:0] stat_q;

   // Saturating count of delivered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= '0;
      else if (done_hs_c && (stat_q != {STAT_W{1'b1}})) stat_q <= stat_q + STAT_W'(1);
   end

   assign stat_jobs = stat_q;
`endif

endmodule
